// File: rtl/ps2_host_transmitter_if.sv
// Host-side PS/2 transmitter bus: command handshake plus the open-drain
// pin view (KClock/KData in) and pull-low enables (KClockDrive/KDataDrive out).
interface ps2_host_transmitter_if;
    logic [7:0] TxData;
    logic       TxStart;
    logic       KClock;
    logic       KData;
    logic       KClockDrive;
    logic       KDataDrive;
    logic       TxBusy;
    logic       TxDone;
    logic       TxError;

    // Environment side: issues commands and presents the pin levels.
    modport master (
        output TxData, TxStart, KClock, KData,
        input  KClockDrive, KDataDrive, TxBusy, TxDone, TxError
    );

    // Transmitter side.
    modport slave (
        input  TxData, TxStart, KClock, KData,
        output KClockDrive, KDataDrive, TxBusy, TxDone, TxError
    );
endinterface

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11 device-clocked
// bits (D0..D7, odd parity, stop), device ACK, bus release.
// Optional macro PS2_TX_ACK_CHECK_EN: a NACK on the ACK bit ends in TxError
// instead of TxDone. Requires INHIBIT_CYCLES >= 2.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned START_TIMEOUT  = 1500000,
    parameter int unsigned BIT_TIMEOUT    = 200000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    ps2_host_transmitter_if.slave bus
);

    localparam int unsigned MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned MAX_T = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);

    // KDataDrive is raised one cycle before KClockDrive drops, so the inhibit
    // terminal count is two short of the full period.
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_REL,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic             kclk_drv_q, kclk_drv_d;
    logic             kdat_drv_q, kdat_drv_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             kclk_s1_q, kclk_s2_q, kclk_prev_q;
    logic             kdat_s1_q, kdat_s2_q;
    logic             kclk_fall;

    assign kclk_fall = kclk_prev_q & ~kclk_s2_q;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    assign bus.KClockDrive = kclk_drv_q;
    assign bus.KDataDrive  = kdat_drv_q;
    assign bus.TxBusy      = (state_q != S_IDLE);
    assign bus.TxDone      = done_q;
    assign bus.TxError     = err_q;

    // State, counters, drives and pin synchronizers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            kclk_drv_q  <= 1'b0;
            kdat_drv_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdat_s1_q   <= 1'b1;
            kdat_s2_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            kclk_drv_q  <= kclk_drv_d;
            kdat_drv_q  <= kdat_drv_d;
            done_q      <= done_d;
            err_q       <= err_d;
            kclk_s1_q   <= bus.KClock;
            kclk_s2_q   <= kclk_s1_q;
            kclk_prev_q <= kclk_s2_q;
            kdat_s1_q   <= bus.KData;
            kdat_s2_q   <= kdat_s1_q;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        bit_d      = bit_q;
        frame_d    = frame_q;
        kclk_drv_d = kclk_drv_q;
        kdat_drv_d = kdat_drv_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.TxStart) begin
                    frame_d    = {1'b1, ~(^bus.TxData), bus.TxData};
                    bit_d      = '0;
                    kclk_drv_d = 1'b1;
                    state_d    = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    kdat_drv_d = 1'b1;
                    state_d    = S_RTS;
                end
            end

            S_RTS: begin
                kclk_drv_d = 1'b0;
                cnt_d      = '0;
                state_d    = S_REQ;
            end

            S_REQ: begin
                if (kclk_fall) begin
                    kdat_drv_d = ~frame_q[0];
                    bit_d      = 4'd1;
                    cnt_d      = '0;
                    state_d    = S_SEND;
                end else if (cnt_q == START_LAST) begin
                    kclk_drv_d = 1'b0;
                    kdat_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ERROR;
                end
            end

            S_SEND: begin
                if (kclk_fall) begin
                    kdat_drv_d = ~frame_q[bit_q];
                    bit_d      = bit_q + 4'd1;
                    cnt_d      = '0;
                    if (bit_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    kclk_drv_d = 1'b0;
                    kdat_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ERROR;
                end
            end

            S_ACK: begin
                if (kclk_fall) begin
                    cnt_d   = '0;
`ifdef PS2_TX_ACK_CHECK_EN
                    if (kdat_s2_q) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_WAIT_REL;
                    end
`else
                    state_d = S_WAIT_REL;
`endif
                end else if (cnt_q == BIT_LAST) begin
                    kclk_drv_d = 1'b0;
                    kdat_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ERROR;
                end
            end

            S_WAIT_REL: begin
                if (kclk_s2_q && kdat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == BIT_LAST) begin
                    kclk_drv_d = 1'b0;
                    kdat_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ERROR;
                end
            end

            S_ERROR: begin
                kclk_drv_d = 1'b0;
                kdat_drv_d = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                kclk_drv_d = 1'b0;
                kdat_drv_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

endmodule
